// File: rtl/ac97_status_rx_pkg.sv
// ac97_status_rx shared constants and state types.
// Frame geometry, slot boundaries and tag bit positions.
package ac97_status_rx_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SLOT_W    = 20;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [7:0] TAG_END  = 8'd15;
  localparam logic [7:0] S1_END   = 8'd35;
  localparam logic [7:0] S2_END   = 8'd55;
  localparam logic [7:0] S3_END   = 8'd75;
  localparam logic [7:0] S4_END   = 8'd95;

  localparam int TAG_READY = 15;
  localparam int TAG_V1    = 14;
  localparam int TAG_V2    = 13;
  localparam int TAG_V3    = 12;
  localparam int TAG_V4    = 11;

  typedef enum logic {
    HUNT,
    LOCKED
  } align_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_WAIT
  } rd_state_t;

endpackage

// File: rtl/ac97_status_rx_frame_align.sv
// ac97_frame_align: SYNC edge detect, bit counter and
// alignment FSM for the AC'97 receive path.
module ac97_frame_align (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  output logic       locked,
  output logic [7:0] bit_idx,
  output logic       commit,
  output logic       fault,
  output logic       sync_err
);

  import ac97_status_rx_pkg::*;

  align_state_t st, st_n;
  logic         sync_q;
  logic         rise;
  logic [7:0]   idx_n;

  assign rise   = sync & ~sync_q;
  assign locked = (st == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= HUNT;
      bit_idx  <= '0;
      sync_q   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      st       <= st_n;
      bit_idx  <= idx_n;
      sync_q   <= sync;
      sync_err <= fault;
    end
  end

  // A rise on the last bit closes the frame; anywhere else it realigns.
  always_comb begin
    st_n   = st;
    idx_n  = bit_idx + 8'd1;
    commit = 1'b0;
    fault  = 1'b0;
    unique case (st)
      HUNT: begin
        idx_n = '0;
        if (rise) st_n = LOCKED;
      end
      LOCKED: begin
        if (rise) begin
          idx_n = '0;
          if (bit_idx == LAST_IDX) commit = 1'b1;
          else                     fault  = 1'b1;
        end else if (bit_idx == LAST_IDX) begin
          fault = 1'b1;
          st_n  = HUNT;
        end
      end
      default: st_n = HUNT;
    endcase
  end

endmodule

// File: rtl/ac97_status_rx.sv
// ac97_status_rx: AC'97 SDATA_IN deserializer with register readback.
// Define AC97_RX_PCM_EN to enable slot 3/4 PCM capture.
module ac97_status_rx #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        BIT_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic        SYNC,
  input  logic        SDATA_IN,
  input  logic        rd_req,
  input  logic [6:0]  rd_addr,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_sig,
  output logic        codec_ready,
  output logic [6:0]  STATUS_ADDR,
  output logic [15:0] STATUS_DATA,
  output logic        status_valid,
  output logic [19:0] PCM_LEFT,
  output logic [19:0] PCM_RIGHT,
  output logic        pcm_valid,
  output logic        rd_busy,
  output logic        rd_done,
  output logic [15:0] rd_data,
  output logic        rd_timeout
);

  import ac97_status_rx_pkg::*;

  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_FRAMES);

  logic [7:0]        idx;
  logic              commit;
  logic              fault;
  logic [SLOT_W-1:0] sr;
  logic [SLOT_W-1:0] word;
  logic [15:0]       p_tag;
  logic [6:0]        p_addr;
  logic [15:0]       p_data;
  logic              st_hit;

  ac97_frame_align u_align (
    .clk      (BIT_CLK),
    .rst_n    (SYSTEM_RESET_N),
    .sync     (SYNC),
    .locked   (locked),
    .bit_idx  (idx),
    .commit   (commit),
    .fault    (fault),
    .sync_err (sync_err)
  );

  assign word   = {sr[SLOT_W-2:0], SDATA_IN};
  assign st_hit = p_tag[TAG_V1] & p_tag[TAG_V2];

  logic unused_bits;
  assign unused_bits = ^{sr[SLOT_W-1], p_tag[10:0], word[3:0]};

  always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      sr     <= '0;
      p_tag  <= '0;
      p_addr <= '0;
      p_data <= '0;
    end else begin
      sr <= word;
      unique case (1'b1)
        locked && idx == TAG_END: p_tag  <= word[15:0];
        locked && idx == S1_END:  p_addr <= word[18:12];
        locked && idx == S2_END:  p_data <= word[19:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      frame_sig    <= 1'b0;
      status_valid <= 1'b0;
      codec_ready  <= 1'b0;
      STATUS_ADDR  <= '0;
      STATUS_DATA  <= '0;
    end else begin
      frame_sig    <= commit;
      status_valid <= commit & st_hit;
      if (commit) begin
        codec_ready <= p_tag[TAG_READY];
        STATUS_ADDR <= p_addr;
        STATUS_DATA <= p_data;
      end
    end
  end

`ifdef AC97_RX_PCM_EN
  logic [SLOT_W-1:0] p_left;
  logic [SLOT_W-1:0] p_right;

  always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      p_left    <= '0;
      p_right   <= '0;
      PCM_LEFT  <= '0;
      PCM_RIGHT <= '0;
      pcm_valid <= 1'b0;
    end else begin
      if (locked && idx == S3_END) p_left  <= word;
      if (locked && idx == S4_END) p_right <= word;
      pcm_valid <= commit & p_tag[TAG_V3] & p_tag[TAG_V4];
      if (commit) begin
        PCM_LEFT  <= p_left;
        PCM_RIGHT <= p_right;
      end
    end
  end
`else
  assign PCM_LEFT  = '0;
  assign PCM_RIGHT = '0;
  assign pcm_valid = 1'b0;
`endif

  rd_state_t     rd_st, rd_st_n;
  logic [6:0]    want, want_n;
  logic [TW-1:0] tcnt, tcnt_n, tcnt_inc;
  logic [15:0]   data_n;
  logic          done_n;
  logic          tmo_n;
  logic          hit;

  assign hit      = st_hit && (p_addr == want);
  assign tcnt_inc = (tcnt == TMO) ? tcnt : tcnt + TW'(1);
  assign rd_busy  = (rd_st == RD_WAIT);

  always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      rd_st      <= RD_IDLE;
      want       <= '0;
      tcnt       <= '0;
      rd_data    <= '0;
      rd_done    <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      rd_st      <= rd_st_n;
      want       <= want_n;
      tcnt       <= tcnt_n;
      rd_data    <= data_n;
      rd_done    <= done_n;
      rd_timeout <= tmo_n;
    end
  end

  // Matching uses the pending slots so rd_done lines up with status_valid.
  always_comb begin
    rd_st_n = rd_st;
    want_n  = want;
    tcnt_n  = tcnt;
    data_n  = rd_data;
    done_n  = 1'b0;
    tmo_n   = 1'b0;
    unique case (rd_st)
      RD_IDLE: begin
        if (rd_req) begin
          rd_st_n = RD_WAIT;
          want_n  = rd_addr;
          tcnt_n  = '0;
          data_n  = '0;
        end
      end
      RD_WAIT: begin
        if (fault) begin
          tmo_n   = 1'b1;
          rd_st_n = RD_IDLE;
        end else if (commit) begin
          if (hit) begin
            done_n  = 1'b1;
            data_n  = p_data;
            rd_st_n = RD_IDLE;
          end else begin
            tcnt_n = tcnt_inc;
            if (tcnt_inc == TMO) begin
              tmo_n   = 1'b1;
              rd_st_n = RD_IDLE;
            end
          end
        end
      end
      default: rd_st_n = RD_IDLE;
    endcase
  end

endmodule

// File: doc/ac97_status_rx.md
# ac97_status_rx

Receive-side AC'97 link deserializer for the codec's SDATA_IN stream. It locks to SYNC and splits each 256-bit frame into the tag, the status-address and status-data slots, and optionally the PCM capture slots. It also runs a register-readback handshake that waits for the codec to return the register addressed by a command-path read. It sits beside the volume/command generator on BIT_CLK and closes the loop on register writes and reads.

## Interface
- TIMEOUT_FRAMES, 4: committed frames to wait for a matching status return before `rd_timeout`.
- BIT_CLK  in  1: AC'97 bit clock; all state changes on its rising edge.
- SYSTEM_RESET_N  in  1: reset, asynchronous and active-low.
- SYNC  in  1: frame sync from the link.
- SDATA_IN  in  1: serial data from the codec, MSB first.
- rd_req  in  1: request a readback; sampled only when `rd_busy`=0.
- rd_addr  in  7: register index to wait for.
- locked  out  1: frame alignment held.
- sync_err  out  1: one-cycle pulse on an alignment fault.
- frame_sig  out  1: one-cycle pulse after each committed frame.
- codec_ready  out  1: tag bit 15 of the last committed frame.
- STATUS_ADDR  out  7: slot 1 bits 18:12.
- STATUS_DATA  out  16: slot 2 bits 19:4.
- status_valid  out  1: one-cycle pulse when the committed frame had tag bits 14 and 13 both set.
- PCM_LEFT, PCM_RIGHT  out  20 each: slot 3 and slot 4 data.
- pcm_valid  out  1: one-cycle pulse when tag bits 12 and 11 were both set.
- rd_busy  out  1: readback in progress.
- rd_done  out  1: one-cycle pulse when the matching status is received.
- rd_data  out  16: matched STATUS_DATA, held until the next accepted request.
- rd_timeout  out  1: one-cycle pulse when a readback is abandoned.

## Operation
- Reset: all outputs are 0. Alignment FSM is in HUNT, bit counter is 0, shift register is 0, read FSM is in RD_IDLE.
- SYNC rise: detected at a sample with SYNC=1 when the previous sample had SYNC=0.
- Bit counter:
  - Its value is the index of the bit sampled this cycle.
  - Slot 0 (tag) occupies indices 0-15.
  - Slot n (n≥1) occupies indices 16+20(n-1) through 35+20(n-1).
  - Slot 1 is 16-35, slot 2 is 36-55, slot 3 is 56-75, slot 4 is 76-95.
- Shift register: 20 bits, shifts SDATA_IN in every cycle.
- Captures: at indices 15, 35, 55, 75 and 95 the block captures {sr[18:0], SDATA_IN} into pending registers for tag (low 16 bits) and slots 1-4.
- Alignment FSM:
  - HUNT: on a SYNC rise, counter ← 0 and go to LOCKED. The partial frame is never committed.
  - LOCKED: counter increments, wrapping 255→0.
  - SYNC rise at counter=255: commit pending registers to outputs and pulse `frame_sig`.
  - SYNC rise at counter≠255: pulse `sync_err`, counter ← 0, stay LOCKED, discard the frame.
  - Counter=255 with no SYNC rise: pulse `sync_err`, go to HUNT, no commit.
- Commit: loads codec_ready, STATUS_ADDR, STATUS_DATA, PCM_LEFT and PCM_RIGHT unconditionally. Valid pulses follow the tag bits. Non-valid slots still update their data outputs.
- Read FSM:
  - RD_IDLE: when `rd_req`=1, latch rd_addr, clear the frame counter, go to RD_WAIT with `rd_busy`=1.
  - RD_WAIT, on each commit: if status_valid and STATUS_ADDR equals the latched address, set rd_data, pulse `rd_done`, return to RD_IDLE.
  - RD_WAIT, on a commit with no match: the frame counter increments. When it reaches TIMEOUT_FRAMES, pulse `rd_timeout` and return to RD_IDLE.
  - `sync_err` in RD_WAIT: abort with `rd_timeout`.
  - `rd_req` while busy is ignored.
- Arithmetic: the timeout counter is $clog2(TIMEOUT_FRAMES+1) bits wide and saturates.

## Timing
- Commit and all pulses are registered. They appear in the cycle after the counter=255 sample and last exactly one cycle.
- Capture-to-output latency:
  - Slot 2 → STATUS_DATA: 201 cycles.
  - Last bit of frame → frame_sig: 1 cycle.
- `rd_done` is coincident with `status_valid`. `rd_busy` falls in the same cycle as `rd_done` or `rd_timeout`.
- Reset mid-frame clears everything asynchronously. Relock requires a fresh SYNC rise.
- Simultaneous `rd_req` and a matching commit in RD_IDLE: the request is accepted, and that commit is not matched.

## Configuration
- AC97_RX_PCM_EN defined: slot 3/4 capture, PCM_LEFT, PCM_RIGHT and pcm_valid are active.
- AC97_RX_PCM_EN undefined: the slot 3/4 registers are omitted, and PCM_LEFT, PCM_RIGHT and pcm_valid are tied to 0. All other behaviour is unchanged.

## Structure
- Shared package holds:
  - The frame-length constant 256 and the slot width 20.
  - Slot end indices 15/35/55/75/95.
  - Tag bit positions.
  - The alignment state enum {HUNT, LOCKED} and the read state enum {RD_IDLE, RD_WAIT}.
- Sub-module `ac97_frame_align`: SYNC edge detect, bit counter, alignment FSM and sync_err. Slot capture, commit and the read FSM stay in the top.

## Test plan
- Two aligned frames, tag 16'hE000, slot 1 addr 7'h18, slot 2 data 16'h0808:
  - Required: after the second frame end, locked=1 and STATUS_ADDR=7'h18, STATUS_DATA=16'h0808.
  - Required: one status_valid pulse with frame_sig.
- Tag 16'h9800, slots 3/4 = 20'hABCDE / 20'h12345:
  - With the macro: pcm_valid pulses and PCM_LEFT/PCM_RIGHT match.
  - Without the macro: both outputs stay 0.
- rd_req with rd_addr=7'h02, then frames with addr 7'h18 followed by a frame with addr 7'h02 and data 16'h8000:
  - Required: rd_done on the third commit and rd_data=16'h8000.
- rd_req with addr 7'h7C and TIMEOUT_FRAMES=4, no match:
  - Required: rd_timeout exactly after the 4th commit, then rd_busy=0.
- SYNC rise at counter 100 while locked:
  - Required: sync_err pulse, that frame not committed, next frame commits normally.
  - Same event during RD_WAIT: also pulses rd_timeout.
- Missing SYNC at counter 255: sync_err, locked=0, no frame_sig until a SYNC rise followed by a full frame.
